// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle floating-point divider between
// N_REQ requesters, with a watchdog that forces a quiet-NaN result on a hang.
module fp_div_arbiter #(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_op_a,
  input  logic [N_REQ*DATA_W-1:0]   req_op_b,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]         rsp_res,
  output logic                      rsp_timeout,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_op_a,
  output logic [DATA_W-1:0]         div_op_b,
  input  logic                      div_done,
  input  logic [DATA_W-1:0]         div_res
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] TIMEOUT_NAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(DATA_W - EXP_W - 2){1'b0}}};
  localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W:0]     cand;
  logic               any_req;
  logic [CNT_W-1:0]   wd_cnt;
  logic               wd_expired;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(N_REQ)) cand = cand - (PTR_W + 1)'(N_REQ);
      if (!any_req && req_valid[cand[PTR_W-1:0]]) begin
        any_req = 1'b1;
        winner  = cand[PTR_W-1:0];
      end
    end
  end

  assign ptr_next   = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (any_req) state_next = S_SETUP;
      S_SETUP: state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (div_done || wd_expired) state_next = S_RESP;
      S_RESP:  if (rsp_ready[owner]) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic; grants are suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    div_start = 1'b0;
    case (state)
      S_IDLE:  if (any_req && !rst) req_ready = ONE_HOT_0 << winner;
      S_START: div_start = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, ownership, watchdog and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      owner       <= '0;
      div_op_a    <= '0;
      div_op_b    <= '0;
      wd_cnt      <= '0;
      rsp_valid   <= '0;
      rsp_res     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            div_op_a <= req_op_a[int'(winner) * DATA_W +: DATA_W];
            div_op_b <= req_op_b[int'(winner) * DATA_W +: DATA_W];
            owner    <= winner;
            rr_ptr   <= ptr_next;
          end
        end
        S_START: wd_cnt <= '0;
        S_WAIT: begin
          // A real completion wins even on the cycle the watchdog would fire.
          if (div_done) begin
            rsp_res     <= div_res;
            rsp_timeout <= 1'b0;
            rsp_valid   <= ONE_HOT_0 << owner;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_expired) begin
              rsp_res     <= TIMEOUT_NAN;
              rsp_timeout <= 1'b1;
              rsp_valid   <= ONE_HOT_0 << owner;
            end
          end
        end
        S_RESP: if (rsp_ready[owner]) rsp_valid <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter: round-robin order, latency, backpressure,
// stray done pulses, watchdog NaN, done-at-threshold priority and async reset.
module tb_fp_div_arbiter;

  localparam int DATA_W  = 32;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 255;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_op_a;
  logic [N_REQ*DATA_W-1:0] req_op_b;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_res;
  logic                    rsp_timeout;
  logic                    div_start;
  logic [DATA_W-1:0]       div_op_a;
  logic [DATA_W-1:0]       div_op_b;
  logic                    div_done;
  logic [DATA_W-1:0]       div_res;

  int checks = 0;
  int errors = 0;

  fp_div_arbiter #(
    .DATA_W(DATA_W), .EXP_W(8), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_timeout(rsp_timeout),
    .div_start(div_start), .div_op_a(div_op_a), .div_op_b(div_op_b),
    .div_done(div_done), .div_res(div_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_op_a[i*DATA_W +: DATA_W] = a;
    req_op_b[i*DATA_W +: DATA_W] = b;
  endtask

  // Divider model: hand-computed quotients for the operand pairs used here.
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: return 32'h40400000; // 6/2 = 3
      {32'h3F800000, 32'h40800000}: return 32'h3E800000; // 1/4 = 0.25
      {32'h3F800000, 32'h40000000}: return 32'h3F000000; // 1/2 = 0.5
      {32'h40800000, 32'h3F800000}: return 32'h40800000; // 4/1 = 4
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // One full transaction. lat = cycles from div_start to div_done (0: never).
  task automatic run_txn(input int own, input int lat, input logic [31:0] exp_res,
                         input logic exp_to, input int hold, input bit stray, input bit keep);
    logic [N_REQ-1:0] oh;
    logic [31:0]      res;
    int               waited;
    int               n;
    oh = N_REQ'(1) << own;
    rsp_ready = (hold > 0) ? ~oh : '1;
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 50) begin
      next();
      waited++;
    end
    check("grant", req_ready, oh);
    if (req_ready != oh) return;
    next();
    if (!keep) req_valid[own] = 1'b0;
    check("setup_quiet", {req_ready, div_start}, 0);
    if (stray) begin
      div_done = 1'b1;
      div_res  = 32'hBAD0BAD0;
    end
    next();
    check("div_start", div_start, 1);
    res = stray ? exp_res : quot(div_op_a, div_op_b);
    for (n = 1; n <= TIMEOUT + 10; n++) begin
      next();
      div_done = (n == lat);
      div_res  = (n == lat) ? res : 32'hBAD0BAD0;
      #1;
      if (rsp_valid != '0) break;
    end
    div_done = 1'b0;
    check("rsp_latency", n, (lat > 0) ? lat + 1 : TIMEOUT + 1);
    check("rsp_valid", rsp_valid, oh);
    check("rsp_res", rsp_res, exp_res);
    check("rsp_timeout", rsp_timeout, exp_to);
    for (int h = 0; h < hold; h++) begin
      next();
      check("bp_valid", rsp_valid, oh);
      check("bp_res", rsp_res, exp_res);
      check("bp_quiet", {req_ready, div_start}, 0);
    end
    if (hold > 0) rsp_ready = '1;
    next();
    check("rsp_clear", rsp_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    div_done  = 1'b0;
    div_res   = '0;
    req_op_a  = '0;
    req_op_b  = '0;
    set_op(0, 32'h40C00000, 32'h40000000);
    set_op(1, 32'h3F800000, 32'h40800000);
    set_op(2, 32'h3F800000, 32'h40000000);
    set_op(3, 32'h40800000, 32'h3F800000);
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_op_a", div_op_a, 0);
    check("rst_op_b", div_op_b, 0);
    check("rst_rsp_res", rsp_res, 0);
    check("rst_timeout", rsp_timeout, 0);
    rst = 1'b0;

    // Round robin with all requesters held valid from reset.
    run_txn(0, 3, 32'h40400000, 1'b0, 0, 1'b0, 1'b1);
    run_txn(1, 7, 32'h3E800000, 1'b0, 0, 1'b0, 1'b1);
    run_txn(2, 1, 32'h3F000000, 1'b0, 0, 1'b0, 1'b1);
    run_txn(3, 4, 32'h40800000, 1'b0, 0, 1'b0, 1'b1);
    run_txn(0, 2, 32'h40400000, 1'b0, 0, 1'b0, 1'b1);
    req_valid = '0;

    // Single request, divider latency 53.
    set_op(1, 32'h40C00000, 32'h40000000);
    req_valid[1] = 1'b1;
    run_txn(1, 53, 32'h40400000, 1'b0, 0, 1'b0, 1'b0);

    // Response backpressure for 10 cycles.
    req_valid[2] = 1'b1;
    run_txn(2, 5, 32'h3F000000, 1'b0, 10, 1'b0, 1'b0);

    // Stray done in SETUP and START, real done 5 cycles into WAIT.
    req_valid[3] = 1'b1;
    run_txn(3, 5, 32'h12345678, 1'b0, 0, 1'b1, 1'b0);

    // Watchdog expiry, then normal service.
    req_valid[0] = 1'b1;
    run_txn(0, 0, 32'h7FC00000, 1'b1, 0, 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    run_txn(1, 3, 32'h40400000, 1'b0, 0, 1'b0, 1'b0);

    // done on the threshold cycle beats the watchdog.
    req_valid[2] = 1'b1;
    run_txn(2, TIMEOUT, 32'h3F000000, 1'b0, 0, 1'b0, 1'b0);

    // Asynchronous reset 20 cycles after div_start.
    set_op(1, 32'h3F800000, 32'h40800000);
    req_valid = '1;
    #1;
    for (int w = 0; w < 50 && req_ready == '0; w++) next();
    next();
    next();
    check("rw_div_start", div_start, 1);
    repeat (20) next();
    #3;
    rst = 1'b1;
    #1;
    check("rw_req_ready", req_ready, 0);
    check("rw_rsp_valid", rsp_valid, 0);
    check("rw_div_start0", div_start, 0);
    check("rw_op_a", div_op_a, 0);
    check("rw_op_b", div_op_b, 0);
    check("rw_rsp_res", rsp_res, 0);
    check("rw_timeout", rsp_timeout, 0);
    for (int c = 0; c < 3; c++) begin
      next();
      check("rw_no_rsp", rsp_valid, 0);
    end
    rst = 1'b0;
    run_txn(0, 4, 32'h40400000, 1'b0, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
